// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared render types and default resolution constants
package render_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} seq_state_t;

  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  localparam int DEF_X_W   = 10;
  localparam int DEF_Y_W   = 10;

  typedef logic [DEF_X_W-1:0] coord_x_t;
  typedef logic [DEF_Y_W-1:0] coord_y_t;

  // Index width for selecting among n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster scan position generator, x inner / y outer
module raster_counter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int X_W   = 10,
  parameter int Y_W   = 10
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

  always_ff @(posedge clk) begin
    if (!resetn || start) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - per-frame render controller: optional clear, then draw engines in turn
module frame_sequencer
  import render_pkg::*;
#(
  parameter int                 H_RES       = DEF_H_RES,
  parameter int                 V_RES       = DEF_V_RES,
  parameter int                 X_W         = DEF_X_W,
  parameter int                 Y_W         = DEF_Y_W,
  parameter int                 PIXEL_W     = 1,
  parameter int                 N_SRC       = 2,
  parameter logic [PIXEL_W-1:0] CLEAR_VALUE = '0,
  parameter int                 DROP_W      = 16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_clk,
  input  logic                       clear_en,
  output logic [N_SRC-1:0]           src_start,
  input  logic [N_SRC-1:0]           src_done,
  input  logic [N_SRC-1:0]           src_we,
  input  logic [N_SRC*X_W-1:0]       src_x,
  input  logic [N_SRC*Y_W-1:0]       src_y,
  input  logic [N_SRC*PIXEL_W-1:0]   src_data,
  output logic [X_W-1:0]             DrawX,
  output logic [Y_W-1:0]             DrawY,
  output logic [PIXEL_W-1:0]         draw_data,
  output logic                       draw_we,
  output logic                       frame_clk_rising_edge,
  output logic                       clear_start,
  output logic                       frame_done,
  output logic                       busy,
  output logic [DROP_W-1:0]          frame_drop_cnt
);

  localparam int               K_W       = idx_width(N_SRC);
  localparam logic [K_W-1:0]   LAST_K    = K_W'(N_SRC - 1);
  localparam logic [N_SRC-1:0] START_ONE = N_SRC'(1);
  localparam logic [X_W:0]     X_LIM     = (X_W + 1)'(H_RES);
  localparam logic [Y_W:0]     Y_LIM     = (Y_W + 1)'(V_RES);

  seq_state_t       state, state_n;
  logic [K_W-1:0]   k, k_n;
  logic             prev_fclk;
  logic             advance, enter_draw;
  logic [X_W-1:0]   rc_x;
  logic [Y_W-1:0]   rc_y;
  logic             rc_last;

  logic               sel_we, sel_ok;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic [PIXEL_W-1:0] sel_data;

  assign sel_we   = src_we[k];
  assign sel_x    = src_x[k*X_W +: X_W];
  assign sel_y    = src_y[k*Y_W +: Y_W];
  assign sel_data = src_data[k*PIXEL_W +: PIXEL_W];
  assign sel_ok   = sel_we && ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);

  // src_start is nonzero only in the first cycle of DRAW_k; done is ignored there.
  assign advance = (state == DRAW) && (src_start == '0) && src_done[k];

  raster_counter #(
    .H_RES(H_RES),
    .V_RES(V_RES),
    .X_W  (X_W),
    .Y_W  (Y_W)
  ) u_clear_scan (
    .clk   (Clk),
    .resetn(Reset),
    .start (state != CLEAR),
    .en    (state == CLEAR),
    .x     (rc_x),
    .y     (rc_y),
    .last  (rc_last)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    case (state)
      IDLE: if (frame_clk_rising_edge) begin
        state_n = clear_en ? CLEAR : DRAW;
        k_n     = '0;
      end
      CLEAR: if (rc_last) begin
        state_n = DRAW;
        k_n     = '0;
      end
      DRAW: if (advance) begin
        if (k == LAST_K) state_n = DONE;
        else             k_n     = k + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    enter_draw = 1'b0;
    case (state)
      IDLE:    enter_draw = frame_clk_rising_edge && !clear_en;
      CLEAR:   enter_draw = rc_last;
      DRAW:    enter_draw = advance && (k != LAST_K);
      default: enter_draw = 1'b0;
    endcase
    busy       = (state != IDLE);
    frame_done = (state == DONE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      prev_fclk             <= 1'b0;
      frame_clk_rising_edge <= 1'b0;
      clear_start           <= 1'b0;
      src_start             <= '0;
      draw_we               <= 1'b0;
      DrawX                 <= '0;
      DrawY                 <= '0;
      draw_data             <= '0;
      frame_drop_cnt        <= '0;
    end else begin
      prev_fclk             <= frame_clk;
      frame_clk_rising_edge <= frame_clk & ~prev_fclk;
      clear_start           <= (state == IDLE) && frame_clk_rising_edge;
      src_start             <= enter_draw ? (START_ONE << k_n) : '0;

      draw_we <= 1'b0;
      if (state == CLEAR) begin
        draw_we   <= 1'b1;
        DrawX     <= rc_x;
        DrawY     <= rc_y;
        draw_data <= CLEAR_VALUE;
      end else if (state == DRAW && sel_ok) begin
        draw_we   <= 1'b1;
        DrawX     <= sel_x;
        DrawY     <= sel_y;
        draw_data <= sel_data;
      end

      // Edges arriving mid-frame are dropped, not queued.
      if (frame_clk_rising_edge && state != IDLE && frame_drop_cnt != '1)
        frame_drop_cnt <= frame_drop_cnt + 1'b1;
    end
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Parametrised per-frame render controller; successor to the fixed single-engine control/clear pair. On each frame_clk rising edge it runs an optional built-in raster clear, then starts N_SRC draw engines in order, muxing each engine's pixel writes onto the single frame-buffer write port, and finally pulses frame_done for the buffer swap. Sits between the VGA timing (frame_clk = VGA_VS), the draw engines / fifo_writer, and frame_buffer.

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines
X_W, 10, x coordinate width (2^X_W >= H_RES)
Y_W, 10, y coordinate width (2^Y_W >= V_RES)
PIXEL_W, 1, pixel data width
N_SRC, 2, number of draw engines (>=1)
CLEAR_VALUE, 0, PIXEL_W-bit value written during clear
DROP_W, 16, width of dropped-frame counter

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-low reset (asserted when 0)
frame_clk  in  1  vsync, Clk-synchronous level
clear_en  in  1  1: clear before drawing; sampled at frame start
src_start  out  N_SRC  one-cycle start pulse, bit k for engine k
src_done  in  N_SRC  engine k finished (level or pulse)
src_we  in  N_SRC  engine k pixel write strobe
src_x  in  N_SRC*X_W  engine k x, packed, engine 0 in LSBs
src_y  in  N_SRC*Y_W  engine k y, packed
src_data  in  N_SRC*PIXEL_W  engine k pixel, packed
DrawX  out  X_W  write x
DrawY  out  Y_W  write y
draw_data  out  PIXEL_W  write pixel
draw_we  out  1  write strobe
frame_clk_rising_edge  out  1  one-cycle pulse per frame_clk rise
clear_start  out  1  one-cycle pulse at frame start (fifo_writer refill)
frame_done  out  1  one-cycle pulse when frame complete
busy  out  1  1 while not IDLE
frame_drop_cnt  out  DROP_W  frames skipped due to overrun

Behaviour:
- Reset (Reset==0 at Clk edge): state IDLE; every output 0; frame_clk history register 0; drop counter 0. Reset mid-frame aborts immediately; no frame_done.
- Edge detect: prev <= frame_clk; rise = frame_clk & ~prev; frame_clk_rising_edge registered = rise (1-cycle latency), pulses on every rise regardless of state.
- States: IDLE, CLEAR, DRAW, DONE. Source index k (clog2(N_SRC) bits, min 1).
- IDLE: on rise -> clear_start=1 next cycle; latch clear_en; go CLEAR if latched 1, else DRAW with k=0.
- CLEAR: raster sweep x inner 0..H_RES-1, y outer 0..V_RES-1; one write per cycle, draw_we=1, draw_data=CLEAR_VALUE; exactly H_RES*V_RES write cycles; after (H_RES-1,V_RES-1) go DRAW, k=0.
- DRAW entry for k: src_start[k]=1 for exactly one cycle (the first cycle in DRAW_k). src_done[k] ignored in that cycle; first sampled the following cycle. On src_done[k]: if k==N_SRC-1 go DONE else k<=k+1 and re-enter DRAW (new start pulse).
- Write mux: in DRAW_k, registered: draw_we<=src_we[k] & (src_x[k]<H_RES) & (src_y[k]<V_RES); DrawX/DrawY/draw_data <= slice k. 1-cycle latency. Writes from engines other than k ignored. src_we[k] coincident with src_done[k] is still forwarded.
- DONE: frame_done=1 one cycle, then IDLE. busy=0 only in IDLE.
- When draw_we=0, DrawX/DrawY/draw_data hold last value.
- Overrun: rise while state!=IDLE -> frame_drop_cnt+1, saturating at all-ones; edge not queued; current frame finishes normally. Rise in the same cycle as DONE->IDLE also counts as dropped.
- clear_en changes mid-frame have no effect.

Decomposition:
- Package render_pkg: seq_state_t enum (IDLE, CLEAR, DRAW, DONE), coordinate typedefs, default resolution constants shared with VGA_controller/frame_buffer.
- Sub-module raster_counter (parameters H_RES, V_RES): start/enable input, x/y outputs, last flag; used for CLEAR.

Test Plan:
- H_RES=4,V_RES=3,N_SRC=2, clear_en=1, one rise -> clear_start pulse, 12 consecutive draw_we cycles (0,0)..(3,2) data 0, then src_start=01, later 10, frame_done pulse after src_done[1].
- clear_en=0, rise -> no clear writes; src_start[0] 2 cycles after rise sample; engine0 writes (2,1,1) -> DrawX=2,DrawY=1,draw_data=1,draw_we=1 one cycle later.
- Engine 0 writes x=4 (>=H_RES) and engine 1 writes during DRAW_0 -> draw_we stays 0 for both.
- Second rise during DRAW -> frame_drop_cnt 0->1, frame continues, frame_done once; DROP_W=2 with 5 overruns -> count saturates at 3.
- src_done[0] held high on start cycle -> ignored, advances the next cycle; src_done as single pulse also advances.
- Reset=0 during CLEAR at pixel 5 -> next cycle all outputs 0, state IDLE, no frame_done; next rise starts a full new frame.
